// File: rtl/regfile_pkg.sv
// Shared constants, typedefs and FSM state encoding for the register file
// and its read-side dump sequencer.
package regfile_pkg;

  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int COUNT_W  = ADDR_W + 1;

  typedef logic [ADDR_W-1:0]  reg_addr_t;
  typedef logic [DATA_W-1:0]  reg_data_t;
  typedef logic [COUNT_W-1:0] reg_count_t;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    SEND,
    FIN
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// Valid/ready stream carrying dumped register values tagged with their address.
interface regfile_dump_if;
  import regfile_pkg::*;

  logic      dout_valid;
  logic      dout_ready;
  reg_data_t dout_data;
  reg_addr_t dout_addr;

  modport master (
    output dout_valid,
    output dout_data,
    output dout_addr,
    input  dout_ready
  );

  modport slave (
    input  dout_valid,
    input  dout_data,
    input  dout_addr,
    output dout_ready
  );

endinterface

// File: rtl/regfile.sv
// 8x8 register file: one synchronous write port (rd) and one combinational
// read port (rs); contents cleared by reset.
module regfile
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      we,
  input  reg_addr_t rd,
  input  reg_data_t in_rd,
  input  reg_addr_t rs,
  output reg_data_t out_rs
);

  reg_data_t regs [NUM_REGS];

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      reg_data_t q_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q_reg <= '0;
        end else if (we && (rd == reg_addr_t'(gi))) begin
          q_reg <= in_rd;
        end
      end

      assign regs[gi] = q_reg;
    end
  endgenerate

  assign out_rs = regs[rs];

endmodule

// File: rtl/regfile_dump.sv
// Walks a wrapping address range through the register file rs port and
// emits each value read as an address-tagged stream beat.
module regfile_dump
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  reg_addr_t             base,
  input  reg_count_t            count,
  output reg_addr_t             rs,
  input  reg_data_t             rs_data,
  regfile_dump_if.master        dout,
  output logic                  busy,
  output logic                  done
);

  dump_state_t state;
  reg_count_t  remaining;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      rs              <= '0;
      remaining       <= '0;
      dout.dout_valid <= 1'b0;
      dout.dout_data  <= '0;
      dout.dout_addr  <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (count != '0) begin
              rs        <= base;
              remaining <= count;
              state     <= ADDR;
            end else begin
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        // The value seen on rs_data now is the pre-write value of any
        // same-cycle register file write.
        ADDR: begin
          dout.dout_data  <= rs_data;
          dout.dout_addr  <= rs;
          dout.dout_valid <= 1'b1;
          state           <= SEND;
        end
        SEND: begin
          if (dout.dout_ready) begin
            dout.dout_valid <= 1'b0;
            if (remaining > reg_count_t'(1)) begin
              remaining <= remaining - reg_count_t'(1);
              rs        <= rs + reg_addr_t'(1);
              state     <= ADDR;
            end else begin
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_count_legal: assert property (
    @(posedge clk) disable iff (reset)
      (state == IDLE && start) |-> (count <= reg_count_t'(NUM_REGS))
  );

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump driving a real register file; a scoreboard queue
// holds expected beats, popped by a negedge stream monitor.
module tb_regfile_dump;
  import regfile_pkg::*;

  logic       clk;
  logic       reset;
  logic       start;
  reg_addr_t  base;
  reg_count_t count;
  reg_addr_t  rs;
  reg_data_t  rs_data;
  logic       busy;
  logic       done;
  logic       we;
  reg_addr_t  rd;
  reg_data_t  in_rd;

  regfile_dump_if dout_if ();

  regfile u_rf (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .rd     (rd),
    .in_rd  (in_rd),
    .rs     (rs),
    .out_rs (rs_data)
  );

  regfile_dump dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .base    (base),
    .count   (count),
    .rs      (rs),
    .rs_data (rs_data),
    .dout    (dout_if.master),
    .busy    (busy),
    .done    (done)
  );

  typedef struct packed {
    reg_addr_t  addr;
    reg_data_t  data;
  } beat_t;

  typedef struct packed {
    reg_addr_t  base;
    reg_count_t count;
    logic [3:0] pre_hi;
    reg_addr_t  last_addr;
    reg_data_t  last_data;
  } vec_t;

  beat_t     sb[$];
  reg_data_t mem_model [NUM_REGS];
  int        n_checks = 0;
  int        n_fail   = 0;
  int        beat_cnt = 0;
  int        done_cnt = 0;
  reg_addr_t last_addr;
  reg_data_t last_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Stream monitor: handshakes complete at the following posedge.
  initial begin
    logic      prev_hold;
    reg_data_t prev_data;
    reg_addr_t prev_addr;
    beat_t     exp_b;
    prev_hold = 1'b0;
    prev_data = '0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_hold = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (prev_hold) begin
          check("hold_valid", int'(dout_if.dout_valid), 1);
          check("hold_data", int'(dout_if.dout_data), int'(prev_data));
          check("hold_addr", int'(dout_if.dout_addr), int'(prev_addr));
        end
        if (dout_if.dout_valid && dout_if.dout_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            exp_b = sb.pop_front();
            check("beat_addr", int'(dout_if.dout_addr), int'(exp_b.addr));
            check("beat_data", int'(dout_if.dout_data), int'(exp_b.data));
          end
          $display("beat addr=%0d data=0x%02h", dout_if.dout_addr, dout_if.dout_data);
          beat_cnt++;
          last_addr = dout_if.dout_addr;
          last_data = dout_if.dout_data;
        end
        prev_hold = dout_if.dout_valid && !dout_if.dout_ready;
        prev_data = dout_if.dout_data;
        prev_addr = dout_if.dout_addr;
      end
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic write_reg(input reg_addr_t a, input reg_data_t d);
    we    = 1'b1;
    rd    = a;
    in_rd = d;
    @(posedge clk); #1;
    we = 1'b0;
    mem_model[a] = d;
  endtask

  task automatic start_dump(input reg_addr_t b, input reg_count_t c);
    beat_t e;
    start = 1'b1;
    base  = b;
    count = c;
    for (int k = 0; k < int'(c); k++) begin
      e.addr = b + reg_addr_t'(k);
      e.data = mem_model[e.addr];
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == d0) check("done_timeout", 0, 1);
  endtask

  initial begin
    vec_t      vecs [4];
    int        d0;
    int        b0;
    int        n;
    reg_addr_t a;

    vecs[0] = '{base: 3'd0, count: 4'd8, pre_hi: 4'h1, last_addr: 3'd7, last_data: 8'h17};
    vecs[1] = '{base: 3'd6, count: 4'd4, pre_hi: 4'hA, last_addr: 3'd1, last_data: 8'hA1};
    vecs[2] = '{base: 3'd3, count: 4'd5, pre_hi: 4'hC, last_addr: 3'd7, last_data: 8'hC7};
    vecs[3] = '{base: 3'd5, count: 4'd8, pre_hi: 4'h3, last_addr: 3'd4, last_data: 8'h34};

    for (int i = 0; i < NUM_REGS; i++) mem_model[i] = '0;
    reset = 1'b1;
    start = 1'b0;
    base  = '0;
    count = '0;
    we    = 1'b0;
    rd    = '0;
    in_rd = '0;
    dout_if.dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_valid", int'(dout_if.dout_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rs", int'(rs), 0);
    check("rst_data", int'(dout_if.dout_data), 0);
    $display("reset checked");

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < int'(vecs[i].count); k++) begin
        a = vecs[i].base + reg_addr_t'(k);
        write_reg(a, {vecs[i].pre_hi, 1'b0, a});
      end
      d0 = done_cnt;
      b0 = beat_cnt;
      start_dump(vecs[i].base, vecs[i].count);
      wait_done(d0, 60);
      check("vec_beats", beat_cnt - b0, int'(vecs[i].count));
      check("vec_done", done_cnt - d0, 1);
      check("vec_last_addr", int'(last_addr), int'(vecs[i].last_addr));
      check("vec_last_data", int'(last_data), int'(vecs[i].last_data));
      check("vec_busy_after", int'(busy), 0);
      $display("dump base=%0d count=%0d beats=%0d", vecs[i].base, vecs[i].count, beat_cnt - b0);
    end

    // Backpressure: single beat held for five cycles
    write_reg(3'd1, 8'h55);
    dout_if.dout_ready = 1'b0;
    d0 = done_cnt;
    b0 = beat_cnt;
    start_dump(3'd1, 4'd1);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", int'(dout_if.dout_valid), 1);
      check("bp_data", int'(dout_if.dout_data), 8'h55);
      check("bp_addr", int'(dout_if.dout_addr), 1);
    end
    @(posedge clk); #1;
    dout_if.dout_ready = 1'b1;
    wait_done(d0, 20);
    check("bp_beats", beat_cnt - b0, 1);
    check("bp_done", done_cnt - d0, 1);
    $display("backpressure dump beats=%0d", beat_cnt - b0);

    // Zero count: done follows the accepting edge, no beat
    d0 = done_cnt;
    b0 = beat_cnt;
    start_dump(3'd3, 4'd0);
    @(negedge clk);
    check("zero_done", int'(done), 1);
    check("zero_valid", int'(dout_if.dout_valid), 0);
    @(posedge clk); #1;
    check("zero_done_low", int'(done), 0);
    check("zero_busy", int'(busy), 0);
    check("zero_beats", beat_cnt - b0, 0);
    check("zero_done_cnt", done_cnt - d0, 1);
    $display("zero-count dump done");

    // Start while busy is ignored
    d0 = done_cnt;
    b0 = beat_cnt;
    start_dump(3'd2, 4'd3);
    @(posedge clk); #1;
    start = 1'b1;
    base  = 3'd0;
    count = 4'd8;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d0, 40);
    repeat (6) @(posedge clk);
    #1;
    check("busy_start_beats", beat_cnt - b0, 3);
    check("busy_start_done", done_cnt - d0, 1);
    check("busy_start_last", int'(last_addr), 4);
    $display("start-while-busy dump beats=%0d", beat_cnt - b0);

    // Reset mid-dump
    d0 = done_cnt;
    b0 = beat_cnt;
    start_dump(3'd0, 4'd8);
    n = 0;
    while (beat_cnt < b0 + 2 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_two_beats", beat_cnt - b0, 2);
    dout_if.dout_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_valid_pre", int'(dout_if.dout_valid), 1);
    #2 reset = 1'b1;
    #1;
    check("mid_valid_drop", int'(dout_if.dout_valid), 0);
    check("mid_busy_drop", int'(busy), 0);
    sb.delete();
    for (int i = 0; i < NUM_REGS; i++) mem_model[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    dout_if.dout_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("mid_no_done", done_cnt - d0, 0);
    check("mid_no_beats", beat_cnt - b0, 2);
    d0 = done_cnt;
    b0 = beat_cnt;
    start_dump(3'd0, 4'd1);
    wait_done(d0, 20);
    check("post_rst_beats", beat_cnt - b0, 1);
    check("post_rst_data", int'(last_data), 0);
    $display("reset mid-dump recovered, R0=0x%02h", last_data);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
